// File: rtl/hbm_arb_pkg.sv
// Shared types and constants for the HBM channel arbiter.
//   AXI_ID_W        : AXI3 ID width on the HBM port
//   AXI_* constants : single-beat INCR bursts of 32 bytes
//   wr_state_e      : write-issue FSM states
//   id_width()      : requester-index width for a given port count
package hbm_arb_pkg;

  localparam int unsigned AXI_ID_W       = 6;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_32B   = 3'b101;
  localparam logic [3:0]  AXI_LEN_1BEAT  = 4'd0;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_SEND = 1'b1
  } wr_state_e;

  // Width of the requester index; never below 1 bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hbm_channel_arbiter_if.sv
// AXI3 pseudo-channel port between the arbiter (master) and the HBM-side
// CDC FIFO controller (slave). Carries AR, R, AW, W and B channels.
//   AWIDTH : byte address width
//   DWIDTH : data beat width
interface hbm_channel_arbiter_if #(
  parameter int unsigned AWIDTH = 33,
  parameter int unsigned DWIDTH = 256
) ();
  import hbm_arb_pkg::*;

  logic [AWIDTH-1:0]   araddr;
  logic [AXI_ID_W-1:0] arid;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [DWIDTH-1:0]   rdata;
  logic [AXI_ID_W-1:0] rid;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [AWIDTH-1:0]   awaddr;
  logic [AXI_ID_W-1:0] awid;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DWIDTH-1:0]   wdata;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [AXI_ID_W-1:0] bid;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arid, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rid, rlast, rvalid, output rready,
    output awaddr, awid, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input  bid, bvalid, output bready
  );

  modport slave (
    input  araddr, arid, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rid, rlast, rvalid, input rready,
    input  awaddr, awid, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wlast, wvalid, output wready,
    output bid, bvalid, input bready
  );

endinterface

// File: rtl/hbm_rr_arbiter.sv
// Round-robin grant: first requesting port at or after ptr, wrapping.
//   req       : per-port request vector
//   ptr       : highest-priority port index
//   en        : grant enable; no grant when low
//   gnt_c     : one-hot (or zero) grant
//   gnt_idx_c : index of the granted port
//   gnt_vld_c : a grant was issued
module hbm_rr_arbiter
  import hbm_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDW       = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDW-1:0]       ptr,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] gnt_c,
  output logic [IDW-1:0]       gnt_idx_c,
  output logic                 gnt_vld_c
);

  logic [IDW-1:0] cand_c;

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    cand_c    = '0;
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      cand_c = IDW'((32'(ptr) + off) % NUM_PORTS);
      if (en && !gnt_vld_c && req[cand_c]) begin
        gnt_c[cand_c] = 1'b1;
        gnt_idx_c     = cand_c;
        gnt_vld_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbm_channel_arbiter.sv
// Shares one HBM pseudo-channel AXI3 master port among NUM_PORTS requesters.
// Round-robin read and write arbitration (independent), single-beat bursts,
// AXI ID = requester index; R/B responses routed back by rid/bid.
// Ports:
//   axi_clk, rst (sync, active-high)
//   req_rd_*  : per-port read requests, req_rd_ready is a same-cycle grant
//   req_wr_*  : per-port write requests (addr+data), req_wr_ready same-cycle
//   rsp_rd_*  : registered read data (broadcast) + one-hot owner
//   rsp_wr_done : registered one-hot write completion pulse
//   axi       : AXI3 master modport toward the HBM side
//   perf_rd_cnt/perf_wr_cnt : R-beat / B counters, only with
//                             `define HBM_ARB_PERF_CNT_EN, else tied to 0
module hbm_channel_arbiter
  import hbm_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned AWIDTH          = 33,
  parameter int unsigned DWIDTH          = 256,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                          axi_clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*AWIDTH-1:0]   req_rd_addr,
  input  logic [NUM_PORTS-1:0]          req_rd_valid,
  output logic [NUM_PORTS-1:0]          req_rd_ready,
  input  logic [NUM_PORTS*AWIDTH-1:0]   req_wr_addr,
  input  logic [NUM_PORTS*DWIDTH-1:0]   req_wr_data,
  input  logic [NUM_PORTS-1:0]          req_wr_valid,
  output logic [NUM_PORTS-1:0]          req_wr_ready,
  output logic [DWIDTH-1:0]             rsp_rd_data,
  output logic [NUM_PORTS-1:0]          rsp_rd_valid,
  output logic [NUM_PORTS-1:0]          rsp_wr_done,
  hbm_channel_arbiter_if.master         axi,
  output logic [31:0]                   perf_rd_cnt,
  output logic [31:0]                   perf_wr_cnt
);

  localparam int unsigned IDW     = id_width(NUM_PORTS);
  localparam int unsigned CNTW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_OUTSTANDING);

  wr_state_e             wr_state_q, wr_state_d;
  logic                  ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
  logic [AWIDTH-1:0]     araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [AXI_ID_W-1:0]   arid_q, arid_d, awid_q, awid_d;
  logic [DWIDTH-1:0]     wdata_q, wdata_d, rsp_rd_data_q, rsp_rd_data_d;
  logic [IDW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]       rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  logic [NUM_PORTS-1:0]  rsp_rd_valid_q, rsp_rd_valid_d, rsp_wr_done_q, rsp_wr_done_d;
  logic                  rready_q, bready_q;

  logic                  rd_en_c, wr_en_c, rd_gnt_vld_c, wr_gnt_vld_c;
  logic [NUM_PORTS-1:0]  rd_gnt_c, wr_gnt_c;
  logic [IDW-1:0]        rd_idx_c, wr_idx_c;
  logic                  r_beat_c, b_beat_c, rd_dec_c, wr_dec_c;

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] idx);
    return (32'(idx) == NUM_PORTS - 1) ? '0 : idx + IDW'(1);
  endfunction

  // AR slot may take a new request when empty or draining this cycle.
  assign rd_en_c = !rst && (!ar_valid_q || axi.arready) && (rd_out_q < MAX_CNT);
  assign wr_en_c = !rst && (wr_state_q == WR_IDLE) && (wr_out_q < MAX_CNT);

  hbm_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDW(IDW)) u_rd_arb (
    .req(req_rd_valid), .ptr(rd_ptr_q), .en(rd_en_c),
    .gnt_c(rd_gnt_c), .gnt_idx_c(rd_idx_c), .gnt_vld_c(rd_gnt_vld_c)
  );

  hbm_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDW(IDW)) u_wr_arb (
    .req(req_wr_valid), .ptr(wr_ptr_q), .en(wr_en_c),
    .gnt_c(wr_gnt_c), .gnt_idx_c(wr_idx_c), .gnt_vld_c(wr_gnt_vld_c)
  );

  assign req_rd_ready = rd_gnt_c;
  assign req_wr_ready = wr_gnt_c;

  assign r_beat_c = axi.rvalid && rready_q;
  assign b_beat_c = axi.bvalid && bready_q;
  // Guard against stray responses underflowing an empty counter.
  assign rd_dec_c = r_beat_c && axi.rlast && (rd_out_q != '0);
  assign wr_dec_c = b_beat_c && (wr_out_q != '0);

  // Read path: AR slot, outstanding count, R routing.
  always_comb begin
    ar_valid_d     = ar_valid_q;
    araddr_d       = araddr_q;
    arid_d         = arid_q;
    rd_ptr_d       = rd_ptr_q;
    rd_out_d       = rd_out_q;
    rsp_rd_valid_d = '0;
    rsp_rd_data_d  = rsp_rd_data_q;
    if (ar_valid_q && axi.arready) ar_valid_d = 1'b0;
    if (rd_gnt_vld_c) begin
      ar_valid_d = 1'b1;
      araddr_d   = req_rd_addr[rd_idx_c*AWIDTH +: AWIDTH];
      arid_d     = AXI_ID_W'(rd_idx_c);
      rd_ptr_d   = ptr_after(rd_idx_c);
    end
    case ({rd_gnt_vld_c, rd_dec_c})
      2'b10:   rd_out_d = rd_out_q + CNTW'(1);
      2'b01:   rd_out_d = rd_out_q - CNTW'(1);
      default: rd_out_d = rd_out_q;
    endcase
    if (r_beat_c) begin
      rsp_rd_data_d = axi.rdata;
      if (32'(axi.rid) < NUM_PORTS) rsp_rd_valid_d[axi.rid[IDW-1:0]] = 1'b1;
    end
  end

  // Write FSM: AW and W issued together, each retired by its own ready.
  always_comb begin
    wr_state_d    = wr_state_q;
    aw_valid_d    = aw_valid_q;
    w_valid_d     = w_valid_q;
    awaddr_d      = awaddr_q;
    awid_d        = awid_q;
    wdata_d       = wdata_q;
    wr_ptr_d      = wr_ptr_q;
    rsp_wr_done_d = '0;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_gnt_vld_c) begin
          wr_state_d = WR_SEND;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          awaddr_d   = req_wr_addr[wr_idx_c*AWIDTH +: AWIDTH];
          awid_d     = AXI_ID_W'(wr_idx_c);
          wdata_d    = req_wr_data[wr_idx_c*DWIDTH +: DWIDTH];
          wr_ptr_d   = ptr_after(wr_idx_c);
        end
      end
      WR_SEND: begin
        if (axi.awready) aw_valid_d = 1'b0;
        if (axi.wready)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    case ({wr_gnt_vld_c, wr_dec_c})
      2'b10:   wr_out_d = wr_out_q + CNTW'(1);
      2'b01:   wr_out_d = wr_out_q - CNTW'(1);
      default: wr_out_d = wr_out_q;
    endcase
    if (b_beat_c && (32'(axi.bid) < NUM_PORTS)) rsp_wr_done_d[axi.bid[IDW-1:0]] = 1'b1;
  end

  // Write FSM state register.
  always_ff @(posedge axi_clk) begin
    if (rst) wr_state_q <= WR_IDLE;
    else     wr_state_q <= wr_state_d;
  end

  // Datapath and counter registers.
  always_ff @(posedge axi_clk) begin
    if (rst) begin
      ar_valid_q     <= 1'b0;
      araddr_q       <= '0;
      arid_q         <= '0;
      rd_ptr_q       <= '0;
      rd_out_q       <= '0;
      rsp_rd_valid_q <= '0;
      rsp_rd_data_q  <= '0;
      aw_valid_q     <= 1'b0;
      w_valid_q      <= 1'b0;
      awaddr_q       <= '0;
      awid_q         <= '0;
      wdata_q        <= '0;
      wr_ptr_q       <= '0;
      wr_out_q       <= '0;
      rsp_wr_done_q  <= '0;
      rready_q       <= 1'b0;
      bready_q       <= 1'b0;
    end else begin
      ar_valid_q     <= ar_valid_d;
      araddr_q       <= araddr_d;
      arid_q         <= arid_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_out_q       <= rd_out_d;
      rsp_rd_valid_q <= rsp_rd_valid_d;
      rsp_rd_data_q  <= rsp_rd_data_d;
      aw_valid_q     <= aw_valid_d;
      w_valid_q      <= w_valid_d;
      awaddr_q       <= awaddr_d;
      awid_q         <= awid_d;
      wdata_q        <= wdata_d;
      wr_ptr_q       <= wr_ptr_d;
      wr_out_q       <= wr_out_d;
      rsp_wr_done_q  <= rsp_wr_done_d;
      rready_q       <= 1'b1;
      bready_q       <= 1'b1;
    end
  end

  assign axi.araddr  = araddr_q;
  assign axi.arid    = arid_q;
  assign axi.arlen   = AXI_LEN_1BEAT;
  assign axi.arsize  = AXI_SIZE_32B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = ar_valid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awid    = awid_q;
  assign axi.awlen   = AXI_LEN_1BEAT;
  assign axi.awsize  = AXI_SIZE_32B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awvalid = aw_valid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wlast   = w_valid_q;
  assign axi.wvalid  = w_valid_q;
  assign axi.bready  = bready_q;

  assign rsp_rd_data  = rsp_rd_data_q;
  assign rsp_rd_valid = rsp_rd_valid_q;
  assign rsp_wr_done  = rsp_wr_done_q;

`ifdef HBM_ARB_PERF_CNT_EN
  logic [31:0] perf_rd_cnt_q, perf_rd_cnt_d, perf_wr_cnt_q, perf_wr_cnt_d;

  // Free-running completion counters, wrap at 2^32.
  always_comb begin
    perf_rd_cnt_d = perf_rd_cnt_q + 32'(r_beat_c);
    perf_wr_cnt_d = perf_wr_cnt_q + 32'(b_beat_c);
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      perf_rd_cnt_q <= '0;
      perf_wr_cnt_q <= '0;
    end else begin
      perf_rd_cnt_q <= perf_rd_cnt_d;
      perf_wr_cnt_q <= perf_wr_cnt_d;
    end
  end

  assign perf_rd_cnt = perf_rd_cnt_q;
  assign perf_wr_cnt = perf_wr_cnt_q;
`else
  assign perf_rd_cnt = '0;
  assign perf_wr_cnt = '0;
`endif

endmodule

// File: tb/tb_hbm_channel_arbiter.sv
// Directed testbench for hbm_channel_arbiter (4 ports, 33-bit addr, 256-bit data).
module tb_hbm_channel_arbiter;
  import hbm_arb_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 33;
  localparam int unsigned DW = 256;
`ifdef HBM_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              axi_clk;
  logic              rst;
  logic [NP*AW-1:0]  req_rd_addr;
  logic [NP-1:0]     req_rd_valid;
  logic [NP-1:0]     req_rd_ready;
  logic [NP*AW-1:0]  req_wr_addr;
  logic [NP*DW-1:0]  req_wr_data;
  logic [NP-1:0]     req_wr_valid;
  logic [NP-1:0]     req_wr_ready;
  logic [DW-1:0]     rsp_rd_data;
  logic [NP-1:0]     rsp_rd_valid;
  logic [NP-1:0]     rsp_wr_done;
  logic [31:0]       perf_rd_cnt;
  logic [31:0]       perf_wr_cnt;

  hbm_channel_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) axi_if ();

  hbm_channel_arbiter #(
    .NUM_PORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .MAX_OUTSTANDING(16)
  ) dut (
    .axi_clk(axi_clk), .rst(rst),
    .req_rd_addr(req_rd_addr), .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
    .req_wr_addr(req_wr_addr), .req_wr_data(req_wr_data),
    .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .rsp_rd_data(rsp_rd_data), .rsp_rd_valid(rsp_rd_valid), .rsp_wr_done(rsp_wr_done),
    .axi(axi_if.master),
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_rd_valid   = '0;
    req_wr_valid   = '0;
    axi_if.arready = 1'b0;
    axi_if.awready = 1'b0;
    axi_if.wready  = 1'b0;
    axi_if.rvalid  = 1'b0;
    axi_if.rid     = '0;
    axi_if.rlast   = 1'b0;
    axi_if.rdata   = '0;
    axi_if.bvalid  = 1'b0;
    axi_if.bid     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [DW-1:0] pat1, pat2, pat3;
  int g;

  initial begin
    pat1 = {8{32'hDEAD_BEEF}};
    pat2 = {8{32'h1234_5678}};
    pat3 = {8{32'hA5A5_0F0F}};
    req_rd_addr = '0;
    req_wr_addr = '0;
    req_wr_data = '0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();

    // Reset state: requests offered during reset are not granted
    req_rd_valid = 4'b1111;
    req_wr_valid = 4'b1111;
    #1;
    check_eq("rst_rd_ready", req_rd_ready, 4'b0000);
    check_eq("rst_wr_ready", req_wr_ready, 4'b0000);
    check_eq("rst_arvalid", axi_if.arvalid, 1'b0);
    check_eq("rst_awvalid", axi_if.awvalid, 1'b0);
    check_eq("rst_wvalid", axi_if.wvalid, 1'b0);
    check_eq("rst_rready", axi_if.rready, 1'b0);
    check_eq("rst_rsp_rd_valid", rsp_rd_valid, 4'b0000);
    check_eq("rst_perf_rd", perf_rd_cnt, 32'd0);
    do_reset();
    check_eq("rready_on", axi_if.rready, 1'b1);
    check_eq("bready_on", axi_if.bready, 1'b1);

    // Single read from port 2
    axi_if.arready = 1'b1;
    req_rd_addr[2*AW +: AW] = 33'h100;
    req_rd_valid = 4'b0100;
    #1;
    check_eq("rd1_ready", req_rd_ready, 4'b0100);
    tick();
    req_rd_valid = '0;
    check_eq("rd1_arvalid", axi_if.arvalid, 1'b1);
    check_eq("rd1_arid", axi_if.arid, 6'd2);
    check_eq("rd1_araddr", axi_if.araddr, 33'h100);
    tick();
    check_eq("rd1_arvalid_drop", axi_if.arvalid, 1'b0);
    axi_if.rvalid = 1'b1; axi_if.rid = 6'd2; axi_if.rlast = 1'b1; axi_if.rdata = pat1;
    tick();
    axi_if.rvalid = 1'b0;
    check_eq("rd1_rsp_valid", rsp_rd_valid, 4'b0100);
    check_eq("rd1_rsp_data", rsp_rd_data, pat1);
    check_eq("rd1_perf_rd", perf_rd_cnt, PERF ? 32'd1 : 32'd0);
    tick();
    check_eq("rd1_rsp_pulse", rsp_rd_valid, 4'b0000);

    // Round robin, all ports valid, one AR per cycle
    do_reset();
    axi_if.arready = 1'b1;
    req_rd_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq($sformatf("rr_ready%0d", k), req_rd_ready, 4'b0001 << (k % 4));
      tick();
      check_eq($sformatf("rr_arvalid%0d", k), axi_if.arvalid, 1'b1);
      check_eq($sformatf("rr_arid%0d", k), axi_if.arid, 6'(k % 4));
    end
    req_rd_valid = '0;

    // Outstanding limit: 16 issued, one R frees a slot
    do_reset();
    axi_if.arready = 1'b1;
    req_rd_valid = 4'b0001;
    g = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_rd_ready[0]) g++;
      tick();
    end
    check_eq("lim_grants", 32'(g), 32'd16);
    axi_if.rvalid = 1'b1; axi_if.rid = 6'd0; axi_if.rlast = 1'b1;
    #1;
    check_eq("lim_same_cycle", req_rd_ready, 4'b0000);
    tick();
    axi_if.rvalid = 1'b0;
    #1;
    check_eq("lim_17th_ready", req_rd_ready, 4'b0001);
    tick();
    check_eq("lim_17th_arvalid", axi_if.arvalid, 1'b1);
    #1;
    check_eq("lim_full_again", req_rd_ready, 4'b0000);
    req_rd_valid = '0;

    // Write: AW accepted at once, W delayed
    do_reset();
    axi_if.awready = 1'b1;
    req_wr_addr[1*AW +: AW] = 33'h2000;
    req_wr_data[1*DW +: DW] = pat2;
    req_wr_addr[3*AW +: AW] = 33'h1_0000_3000;
    req_wr_data[3*DW +: DW] = pat3;
    req_wr_valid = 4'b0010;
    #1;
    check_eq("wr1_ready", req_wr_ready, 4'b0010);
    tick();
    req_wr_valid = 4'b1010;
    check_eq("wr1_awvalid", axi_if.awvalid, 1'b1);
    check_eq("wr1_wvalid", axi_if.wvalid, 1'b1);
    check_eq("wr1_wlast", axi_if.wlast, 1'b1);
    check_eq("wr1_awid", axi_if.awid, 6'd1);
    check_eq("wr1_awaddr", axi_if.awaddr, 33'h2000);
    check_eq("wr1_wdata", axi_if.wdata, pat2);
    #1;
    check_eq("wr1_send_block", req_wr_ready, 4'b0000);
    tick();
    check_eq("wr1_aw_drop", axi_if.awvalid, 1'b0);
    check_eq("wr1_w_hold", axi_if.wvalid, 1'b1);
    tick();
    check_eq("wr1_w_hold2", axi_if.wvalid, 1'b1);
    axi_if.wready = 1'b1;
    #1;
    check_eq("wr1_still_block", req_wr_ready, 4'b0000);
    tick();
    check_eq("wr1_w_drop", axi_if.wvalid, 1'b0);
    #1;
    check_eq("wr2_ready", req_wr_ready, 4'b1000);
    tick();
    req_wr_valid = '0;
    check_eq("wr2_awid", axi_if.awid, 6'd3);
    check_eq("wr2_awaddr", axi_if.awaddr, 33'h1_0000_3000);
    check_eq("wr2_wdata", axi_if.wdata, pat3);
    tick();
    check_eq("wr2_aw_done", axi_if.awvalid, 1'b0);
    check_eq("wr2_w_done", axi_if.wvalid, 1'b0);
    axi_if.wready = 1'b0;
    axi_if.bvalid = 1'b1; axi_if.bid = 6'd3;
    tick();
    axi_if.bvalid = 1'b0;
    check_eq("b_done", rsp_wr_done, 4'b1000);
    tick();
    check_eq("b_pulse", rsp_wr_done, 4'b0000);
    axi_if.bvalid = 1'b1; axi_if.bid = 6'd5;
    tick();
    axi_if.bvalid = 1'b0;
    check_eq("b_bad_id", rsp_wr_done, 4'b0000);
    axi_if.rvalid = 1'b1; axi_if.rid = 6'd7; axi_if.rlast = 1'b1;
    tick();
    axi_if.rvalid = 1'b0;
    check_eq("r_bad_id", rsp_rd_valid, 4'b0000);
    check_eq("perf_rd", perf_rd_cnt, PERF ? 32'd1 : 32'd0);
    check_eq("perf_wr", perf_wr_cnt, PERF ? 32'd2 : 32'd0);

    // Reset mid-operation with 5 reads outstanding and AR/AW pending
    do_reset();
    for (int p = 0; p < 4; p++) req_rd_addr[p*AW +: AW] = AW'(32'h1000 * (p + 1));
    axi_if.arready = 1'b1;
    req_rd_valid = 4'b1111;
    req_wr_valid = 4'b0100;
    for (int k = 0; k < 5; k++) tick();
    axi_if.arready = 1'b0;
    req_rd_valid = '0;
    req_wr_valid = '0;
    check_eq("mid_arvalid", axi_if.arvalid, 1'b1);
    check_eq("mid_araddr", axi_if.araddr, 33'h1000);
    check_eq("mid_awvalid", axi_if.awvalid, 1'b1);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_arvalid", axi_if.arvalid, 1'b0);
    check_eq("mid_rst_araddr", axi_if.araddr, 33'h0);
    check_eq("mid_rst_awvalid", axi_if.awvalid, 1'b0);
    check_eq("mid_rst_wvalid", axi_if.wvalid, 1'b0);
    check_eq("mid_rst_rready", axi_if.rready, 1'b0);
    rst = 1'b0;
    tick();
    req_rd_valid = 4'b1111;
    req_wr_valid = 4'b1111;
    #1;
    check_eq("mid_rd_ptr0", req_rd_ready, 4'b0001);
    check_eq("mid_wr_ptr0", req_wr_ready, 4'b0001);
    check_eq("mid_perf_rd", perf_rd_cnt, 32'd0);
    req_rd_valid = '0;
    req_wr_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
